tipi_mailbox: RTL and testbench
===============================

Name: tipi_mailbox

Overview:
- Synchronous, parametrised successor to the TI-side latch block.
- Provides NCH TI->RPi mailbox registers, NCH RPi->TI readback registers, and NCRU CRU enable bits. All state lives in the clk domain.
- TI strobes pass through synchronisers and are edge-detected. Each TI->RPi channel has a valid/ack handshake toward the RPi, plus an overrun flag.
- Sits between the TI edge-connector buffers and the RPi GPIO/SPI bridge.

Parameters:
- NCH, 2, number of channels in each direction (1..8).
- DW, 8, data width of each register.
- WR_TOP, 16'h5FFF, TI write address of channel 0. Channel k is at WR_TOP-2k. Readback channel k is at WR_TOP-2*NCH-2k.
- NCRU, 1, number of CRU bits (power of 2, 1..16).
- SYNC_STAGES, 2, synchroniser depth for ti_we, ti_memen, ti_cruclk, ti_reset (>=2).
- GATE_ON_CRU, 1, if 1, decode and output enables are qualified by cru_bits[0].

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  synchronous active-high reset
- ti_a  in  16  TI address, bit 0 = MSB
- ti_data  in  DW  TI data bus, bit 0 = MSB
- ti_memen  in  1  memory enable, active low
- ti_we  in  1  write enable, active low
- ti_dbin  in  1  read strobe, active high
- ti_cruclk  in  1  CRU clock, active low
- ti_reset  in  1  TI reset, active low
- cru_base  in  4  CRU base nibble n in 0x1n00
- rd_oe_n  out  NCH  per-channel readback buffer OE, active low
- tx_data  out  NCH*DW  latched TI->RPi registers, channel k at [k*DW +: DW]
- tx_valid  out  NCH  channel holds unacknowledged data
- tx_ack  in  NCH  RPi consume pulse, one clk
- tx_overrun  out  NCH  sticky: a write arrived while valid and not acked
- ovr_clr  in  1  clears all tx_overrun bits
- rx_data  in  NCH*DW  RPi->TI readback values
- rx_we  in  NCH  RPi load strobe per readback channel
- rx_q  out  NCH*DW  registered readback values, drive buffer inputs
- cru_bits  out  NCRU  CRU enable bits

Behaviour:
- Reset (rst=1 at a clk edge): tx_data=0, tx_valid=0, tx_overrun=0, rx_q=0, cru_bits=0. All synchroniser flops are set to the inactive level (1 for active-low strobes). rd_oe_n=all 1 while rst is asserted.
- Synchronisers: SYNC_STAGES flops per strobe. ti_a and ti_data are sampled every clk through a delay line of the same depth, so address and data are aligned with the synced strobes.
- Write event: synced ti_we 1->0 with synced ti_memen=0.
  - Compare the aligned address against WR_TOP-2k for each k. If GATE_ON_CRU is set, also require cru_bits[0]=1.
  - On a hit, tx_data[k] loads the aligned data on the next edge and tx_valid[k] is set.
  - Latency: strobe edge to tx_valid is SYNC_STAGES+1 clks.
- Handshake:
  - tx_ack[k]=1 clears tx_valid[k] on the next edge.
  - Write hit and tx_ack in the same cycle: the write wins. Data updates, tx_valid stays 1, no overrun.
  - Write hit while tx_valid=1 and no ack: data is overwritten, tx_valid stays 1, tx_overrun[k] is set (sticky).
  - ack while tx_valid=0: ignored.
  - ovr_clr together with a new overrun in the same cycle: the set wins.
- Readback: rx_we[k] loads rx_q[k] from rx_data[k] on the next edge.
- Read enable (combinational from the raw bus, because TI read timing cannot wait for the synchronisers):
  - rd_oe_n[k]=0 iff ~rst, ~ti_memen, ti_dbin, ti_a==WR_TOP-2*NCH-2k, and (cru_bits[0] or !GATE_ON_CRU).
  - Exactly one bit can be low at a time.
- CRU:
  - Event: synced ti_cruclk 1->0 with aligned memen=1, a[3]=1, a[4:7]==cru_base.
  - Bit index = a[15-log2(NCRU) : 14] (0 when NCRU=1). The addressed bit takes a[15].
  - Synced ti_reset=0 clears all cru_bits, with priority over a CRU write.
  - With GATE_ON_CRU set, clearing cru_bits[0] blocks writes and reads but preserves tx/rx contents.
- Non-matching addresses and write events during rst: no state change.
- Back-to-back writes: any writes separated by at least SYNC_STAGES+2 clks are each captured.

Decomposition:
- Package tipi_pkg: default address constants (WR_TOP), a function returning the write/read address for channel k, and CRU decode field positions.
- One sub-module: tipi_sync, a parametrised SYNC_STAGES synchroniser with reset value and falling-edge detect output. Instantiate it once per strobe.
- Address and data delay lines are inline.

Test Plan:
- Reset, then TI write 0xA5 to 0x5FFF with CRU bit 0 set -> tx_data[0]=0xA5 and tx_valid[0]=1 exactly SYNC_STAGES+1 clks after the we falling edge. tx_ack pulse -> valid=0.
- Second write 0x3C to 0x5FFF with no ack -> tx_data[0]=0x3C, tx_overrun[0]=1. ovr_clr -> overrun=0. Write coincident with ack -> valid stays 1, overrun stays 0.
- rx_we[1] with rx_data[1]=0x42, then TI read of 0x5FF9 (memen=0, dbin=1) -> rd_oe_n=2'b01 combinationally, rx_q[1]=0x42. Read of 0x5FFB -> rd_oe_n=2'b10.
- CRU write, cru_base=1, a=0x1100 with a[15]=1 -> cru_bits[0]=1. a[15]=0 -> cleared. cru_base mismatch (a=0x1200) -> no change. ti_reset low -> cru_bits=0.
- GATE_ON_CRU=1 with cru_bits[0]=0: write 0x5FFF and read 0x5FFB -> no tx change, rd_oe_n all 1.
- rst asserted mid-handshake (tx_valid=1, overrun=1) -> all outputs zero on the next edge. NCH=4, NCRU=4 build: channel 3 write at 0x5FF9, readback 3 at 0x5FF1, CRU bit 2 addressed.

Source files
------------

// File: rtl/tipi_pkg.sv
// Shared constants and address helpers for the TI<->RPi mailbox.
// Address fields use natural numbering: TI bit i (bit 0 = MSB) is vector bit 15-i.
package tipi_pkg;

    localparam logic [15:0] WR_TOP_DEF = 16'h5FFF;

    // CRU decode fields in vector numbering (TI a[3], a[4:7], a[15])
    localparam int CRU_SEL_BIT = 12;
    localparam int CRU_BASE_HI = 11;
    localparam int CRU_BASE_LO = 8;
    localparam int CRU_IDX_LO  = 1;
    localparam int CRU_VAL_BIT = 0;

    function automatic logic [15:0] wr_addr(input logic [15:0] top, input int k);
        return top - 16'(2 * k);
    endfunction

    function automatic logic [15:0] rd_addr(input logic [15:0] top, input int nch, input int k);
        return top - 16'(2 * nch) - 16'(2 * k);
    endfunction

endpackage

// File: rtl/tipi_sync.sv
// Multi-flop synchroniser for one TI strobe with a falling-edge detect.
// Reset loads every flop with RST_VAL so no spurious edge appears after reset.
module tipi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            last_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign fall_o = last_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/tipi_mailbox.sv
// TI-side mailbox: TI->RPi registers with valid/ack/overrun, RPi->TI readback
// registers with combinational buffer enables, and CRU enable bits.
module tipi_mailbox
    import tipi_pkg::*;
#(
    parameter int          NCH         = 2,
    parameter int          DW          = 8,
    parameter logic [15:0] WR_TOP      = WR_TOP_DEF,
    parameter int          NCRU        = 1,
    parameter int          SYNC_STAGES = 2,
    parameter int          GATE_ON_CRU = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       ti_a,
    input  logic [DW-1:0]     ti_data,
    input  logic              ti_memen,
    input  logic              ti_we,
    input  logic              ti_dbin,
    input  logic              ti_cruclk,
    input  logic              ti_reset,
    input  logic [3:0]        cru_base,
    output logic [NCH-1:0]    rd_oe_n,
    output logic [NCH*DW-1:0] tx_data,
    output logic [NCH-1:0]    tx_valid,
    input  logic [NCH-1:0]    tx_ack,
    output logic [NCH-1:0]    tx_overrun,
    input  logic              ovr_clr,
    input  logic [NCH*DW-1:0] rx_data,
    input  logic [NCH-1:0]    rx_we,
    output logic [NCH*DW-1:0] rx_q,
    output logic [NCRU-1:0]   cru_bits
);

    localparam int CW = (NCRU > 1) ? $clog2(NCRU) : 1;

    logic we_fall, cru_fall, memen_s, treset_s;
    logic we_lvl_unused, memen_fall_unused, cruclk_lvl_unused, treset_fall_unused;

    tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_we (
        .clk(clk), .rst(rst), .d_i(ti_we), .q_o(we_lvl_unused), .fall_o(we_fall)
    );
    tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_memen (
        .clk(clk), .rst(rst), .d_i(ti_memen), .q_o(memen_s), .fall_o(memen_fall_unused)
    );
    tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cruclk (
        .clk(clk), .rst(rst), .d_i(ti_cruclk), .q_o(cruclk_lvl_unused), .fall_o(cru_fall)
    );
    tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_reset (
        .clk(clk), .rst(rst), .d_i(ti_reset), .q_o(treset_s), .fall_o(treset_fall_unused)
    );

    // Address/data delay lines keep the bus aligned with the synchronised strobes
    logic [15:0]   a_dly_q [SYNC_STAGES];
    logic [DW-1:0] d_dly_q [SYNC_STAGES];
    logic [15:0]   a_al;
    logic [DW-1:0] d_al;

    always_ff @(posedge clk) begin
        a_dly_q[0] <= ti_a;
        d_dly_q[0] <= ti_data;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            a_dly_q[i] <= a_dly_q[i-1];
            d_dly_q[i] <= d_dly_q[i-1];
        end
    end

    assign a_al = a_dly_q[SYNC_STAGES-1];
    assign d_al = d_dly_q[SYNC_STAGES-1];

    logic [NCH*DW-1:0] tx_data_q, tx_data_d, rx_q_q, rx_q_d;
    logic [NCH-1:0]    tx_valid_q, tx_valid_d, tx_ovr_q, tx_ovr_d, hit;
    logic [NCRU-1:0]   cru_q, cru_d;
    logic              gate_en, wr_ev, cru_ev;
    int                cru_idx;

    always_comb begin
        gate_en    = (GATE_ON_CRU == 0) || cru_q[0];
        wr_ev      = we_fall & ~memen_s & gate_en;
        cru_ev     = cru_fall & memen_s & a_al[CRU_SEL_BIT]
                     & (a_al[CRU_BASE_HI:CRU_BASE_LO] == cru_base);
        cru_idx    = (NCRU > 1) ? int'(a_al[CW:CRU_IDX_LO]) : 0;
        hit        = '0;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_ovr_d   = tx_ovr_q;
        rx_q_d     = rx_q_q;
        cru_d      = cru_q;

        for (int k = 0; k < NCH; k++) begin
            hit[k] = wr_ev && (a_al == wr_addr(WR_TOP, k));
            // A write beats a coincident ack; an overrun set beats ovr_clr
            if (hit[k]) begin
                tx_data_d[k*DW +: DW] = d_al;
                tx_valid_d[k]         = 1'b1;
                if (tx_valid_q[k] && !tx_ack[k]) tx_ovr_d[k] = 1'b1;
                else if (ovr_clr)                tx_ovr_d[k] = 1'b0;
            end else begin
                if (tx_ack[k]) tx_valid_d[k] = 1'b0;
                if (ovr_clr)   tx_ovr_d[k]   = 1'b0;
            end
            if (rx_we[k]) rx_q_d[k*DW +: DW] = rx_data[k*DW +: DW];
        end

        if (!treset_s) begin
            cru_d = '0;
        end else if (cru_ev) begin
            for (int i = 0; i < NCRU; i++) begin
                if (i == cru_idx) cru_d[i] = a_al[CRU_VAL_BIT];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_q  <= '0;
            tx_valid_q <= '0;
            tx_ovr_q   <= '0;
            rx_q_q     <= '0;
            cru_q      <= '0;
        end else begin
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_ovr_q   <= tx_ovr_d;
            rx_q_q     <= rx_q_d;
            cru_q      <= cru_d;
        end
    end

    // Read enables come straight off the raw bus: TI read timing cannot wait for sync
    always_comb begin
        rd_oe_n = '1;
        for (int k = 0; k < NCH; k++) begin
            if (!rst && !ti_memen && ti_dbin && gate_en && (ti_a == rd_addr(WR_TOP, NCH, k)))
                rd_oe_n[k] = 1'b0;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign tx_overrun = tx_ovr_q;
    assign rx_q       = rx_q_q;
    assign cru_bits   = cru_q;

endmodule

// File: tb/tb_tipi_mailbox.sv
// Bench for tipi_mailbox: a default build and an NCH=4/NCRU=4 build share the TI bus,
// each with its own CRU base, checked against a transaction-level model.
module tb_tipi_mailbox;

    localparam int S = 2;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        rst, ti_memen, ti_we, ti_dbin, ti_cruclk, ti_reset, ovr_clr;
    logic [15:0] ti_a;
    logic [7:0]  ti_data;

    logic [1:0]  rd_oe_n0, tx_valid0, tx_ack0, tx_overrun0, rx_we0;
    logic [15:0] tx_data0, rx_data0, rx_q0;
    logic [0:0]  cru_bits0;
    logic [3:0]  rd_oe_n1, tx_valid1, tx_ack1, tx_overrun1, rx_we1, cru_bits1;
    logic [31:0] tx_data1, rx_data1, rx_q1;

    tipi_mailbox u_dut0 (
        .clk(clk), .rst(rst), .ti_a(ti_a), .ti_data(ti_data), .ti_memen(ti_memen),
        .ti_we(ti_we), .ti_dbin(ti_dbin), .ti_cruclk(ti_cruclk), .ti_reset(ti_reset),
        .cru_base(4'h1), .rd_oe_n(rd_oe_n0), .tx_data(tx_data0), .tx_valid(tx_valid0),
        .tx_ack(tx_ack0), .tx_overrun(tx_overrun0), .ovr_clr(ovr_clr), .rx_data(rx_data0),
        .rx_we(rx_we0), .rx_q(rx_q0), .cru_bits(cru_bits0)
    );

    tipi_mailbox #(.NCH(4), .NCRU(4)) u_dut1 (
        .clk(clk), .rst(rst), .ti_a(ti_a), .ti_data(ti_data), .ti_memen(ti_memen),
        .ti_we(ti_we), .ti_dbin(ti_dbin), .ti_cruclk(ti_cruclk), .ti_reset(ti_reset),
        .cru_base(4'h2), .rd_oe_n(rd_oe_n1), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ack(tx_ack1), .tx_overrun(tx_overrun1), .ovr_clr(ovr_clr), .rx_data(rx_data1),
        .rx_we(rx_we1), .rx_q(rx_q1), .cru_bits(cru_bits1)
    );

    // Reference model, one row per build
    int         nch[2]   = '{2, 4};
    int         ncru[2]  = '{1, 4};
    logic [3:0] mbase[2] = '{4'h1, 4'h2};
    logic [7:0] m_txd[2][4];
    logic [7:0] m_rxq[2][4];
    logic       m_txv[2][4];
    logic       m_ovr[2][4];
    logic       m_cru[2][4];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++) begin
                m_txd[d][k] = '0; m_rxq[d][k] = '0;
                m_txv[d][k] = 1'b0; m_ovr[d][k] = 1'b0; m_cru[d][k] = 1'b0;
            end
    endfunction

    function automatic logic [63:0] pk8(input int d, input bit rx);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < nch[d]; k++) v[k*8 +: 8] = rx ? m_rxq[d][k] : m_txd[d][k];
        return v;
    endfunction

    function automatic logic [63:0] pk1(input int d, input int sel);
        logic [63:0] v;
        int n;
        v = '0;
        n = (sel == 2) ? ncru[d] : nch[d];
        for (int k = 0; k < n; k++)
            v[k] = (sel == 0) ? m_txv[d][k] : (sel == 1) ? m_ovr[d][k] : m_cru[d][k];
        return v;
    endfunction

    function automatic logic [63:0] exp_oe(input int d, input logic [15:0] addr);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < nch[d]; k++)
            v[k] = !(!rst && m_cru[d][0] &&
                     addr == 16'h5FFF - 16'(2 * nch[d]) - 16'(2 * k));
        return v;
    endfunction

    task automatic check_state(input string tag);
        chk_eq({tag, "/d0 tx_data"},  64'(tx_data0),    pk8(0, 1'b0));
        chk_eq({tag, "/d0 tx_valid"}, 64'(tx_valid0),   pk1(0, 0));
        chk_eq({tag, "/d0 overrun"},  64'(tx_overrun0), pk1(0, 1));
        chk_eq({tag, "/d0 rx_q"},     64'(rx_q0),       pk8(0, 1'b1));
        chk_eq({tag, "/d0 cru"},      64'(cru_bits0),   pk1(0, 2));
        chk_eq({tag, "/d1 tx_data"},  64'(tx_data1),    pk8(1, 1'b0));
        chk_eq({tag, "/d1 tx_valid"}, 64'(tx_valid1),   pk1(1, 0));
        chk_eq({tag, "/d1 overrun"},  64'(tx_overrun1), pk1(1, 1));
        chk_eq({tag, "/d1 rx_q"},     64'(rx_q1),       pk8(1, 1'b1));
        chk_eq({tag, "/d1 cru"},      64'(cru_bits1),   pk1(1, 2));
    endtask

    // TI memory write; ack/clr are presented on the edge where the write lands
    task automatic ti_write(input logic [15:0] addr, input logic [7:0] data,
                            input logic [1:0] ack0, input logic [3:0] ack1, input logic clr);
        logic [3:0] ack;
        logic       hit, so;
        ti_a = addr; ti_data = data; ti_memen = 1'b0; ti_we = 1'b0;
        tick(S);
        chk_eq("wr_early d0 valid", 64'(tx_valid0), pk1(0, 0));
        chk_eq("wr_early d1 valid", 64'(tx_valid1), pk1(1, 0));
        tx_ack0 = ack0; tx_ack1 = ack1; ovr_clr = clr;
        tick(1);
        tx_ack0 = '0; tx_ack1 = '0; ovr_clr = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ack = (d == 0) ? {2'b00, ack0} : ack1;
            for (int k = 0; k < nch[d]; k++) begin
                hit = m_cru[d][0] && (addr == 16'h5FFF - 16'(2 * k));
                so  = hit && m_txv[d][k] && !ack[k];
                if (hit) begin
                    m_txd[d][k] = data;
                    m_txv[d][k] = 1'b1;
                end else if (ack[k]) begin
                    m_txv[d][k] = 1'b0;
                end
                if (so)       m_ovr[d][k] = 1'b1;
                else if (clr) m_ovr[d][k] = 1'b0;
            end
        end
        chk_eq("wr_lat d0 valid", 64'(tx_valid0), pk1(0, 0));
        chk_eq("wr_lat d1 valid", 64'(tx_valid1), pk1(1, 0));
        chk_eq("wr_lat d0 data",  64'(tx_data0),  pk8(0, 1'b0));
        chk_eq("wr_lat d1 data",  64'(tx_data1),  pk8(1, 1'b0));
        ti_we = 1'b1; ti_memen = 1'b1;
        tick(S + 2);
    endtask

    task automatic ack_pulse(input logic [1:0] ack0, input logic [3:0] ack1, input logic clr);
        tx_ack0 = ack0; tx_ack1 = ack1; ovr_clr = clr;
        tick(1);
        tx_ack0 = '0; tx_ack1 = '0; ovr_clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k < 2 && ack0[k]) m_txv[0][k] = 1'b0;
            if (ack1[k])          m_txv[1][k] = 1'b0;
            if (clr) begin
                m_ovr[0][k] = 1'b0;
                m_ovr[1][k] = 1'b0;
            end
        end
    endtask

    task automatic rx_load(input logic [1:0] we0, input logic [15:0] d0,
                           input logic [3:0] we1, input logic [31:0] d1);
        rx_we0 = we0; rx_data0 = d0; rx_we1 = we1; rx_data1 = d1;
        tick(1);
        rx_we0 = '0; rx_we1 = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < 2 && we0[k]) m_rxq[0][k] = d0[k*8 +: 8];
            if (we1[k])          m_rxq[1][k] = d1[k*8 +: 8];
        end
    endtask

    task automatic ti_read(input logic [15:0] addr);
        ti_a = addr; ti_memen = 1'b0; ti_dbin = 1'b1;
        #1;
        chk_eq($sformatf("rd_oe d0 @%h", addr), 64'(rd_oe_n0), exp_oe(0, addr));
        chk_eq($sformatf("rd_oe d1 @%h", addr), 64'(rd_oe_n1), exp_oe(1, addr));
        ti_memen = 1'b1; ti_dbin = 1'b0;
        tick(S + 2);
    endtask

    task automatic cru_write(input logic [15:0] addr);
        int idx;
        ti_a = addr; ti_cruclk = 1'b0;
        tick(S + 1);
        for (int d = 0; d < 2; d++) begin
            if (addr[12] && addr[11:8] == mbase[d]) begin
                idx = (ncru[d] > 1) ? (int'(addr >> 1) & (ncru[d] - 1)) : 0;
                m_cru[d][idx] = addr[0];
            end
        end
        ti_cruclk = 1'b1;
        tick(S + 2);
    endtask

    task automatic ti_reset_pulse();
        ti_reset = 1'b0;
        tick(S + 2);
        for (int k = 0; k < 4; k++) begin
            m_cru[0][k] = 1'b0;
            m_cru[1][k] = 1'b0;
        end
        ti_reset = 1'b1;
        tick(S + 2);
    endtask

    logic [15:0] ra;
    logic [1:0]  a0;
    logic [3:0]  a1;

    initial begin
        rst = 1'b1; ti_memen = 1'b1; ti_we = 1'b1; ti_dbin = 1'b0; ti_cruclk = 1'b1;
        ti_reset = 1'b1; ti_a = '0; ti_data = '0; ovr_clr = 1'b0;
        tx_ack0 = '0; tx_ack1 = '0; rx_we0 = '0; rx_we1 = '0; rx_data0 = '0; rx_data1 = '0;
        model_reset();
        tick(3);
        check_state("reset");
        ti_read(16'h5FFB);
        rst = 1'b0;
        tick(1);

        cru_write(16'h1101);
        cru_write(16'h1201);
        check_state("cru_on");

        ti_write(16'h5FFF, 8'hA5, 2'b00, 4'h0, 1'b0);
        check_state("wr_a5");
        ack_pulse(2'b01, 4'h0, 1'b0);
        check_state("ack");
        ti_write(16'h5FFF, 8'h11, 2'b00, 4'h0, 1'b0);
        ti_write(16'h5FFF, 8'h3C, 2'b00, 4'h0, 1'b0);
        check_state("overrun");
        ack_pulse(2'b00, 4'h0, 1'b1);
        check_state("ovr_clr");
        ti_write(16'h5FFF, 8'h5A, 2'b01, 4'h0, 1'b0);
        check_state("wr_with_ack");
        ti_write(16'h5FFF, 8'h77, 2'b00, 4'h0, 1'b1);
        check_state("ovr_set_vs_clr");

        rx_load(2'b10, 16'h4200, 4'h0, 32'h0);
        ti_read(16'h5FF9);
        ti_read(16'h5FFB);
        check_state("readback");

        cru_write(16'h1100);
        check_state("cru_clr");
        ti_write(16'h5FFF, 8'hEE, 2'b00, 4'h0, 1'b0);
        ti_read(16'h5FFB);
        check_state("gated");
        cru_write(16'h1101);
        cru_write(16'h1200);
        check_state("cru_base_mismatch");
        ti_reset_pulse();
        check_state("ti_reset");

        cru_write(16'h1101);
        cru_write(16'h1201);
        cru_write(16'h1205);
        check_state("cru_bit2");
        ti_write(16'h5FF9, 8'h99, 2'b00, 4'h0, 1'b0);
        rx_load(2'b00, 16'h0, 4'b1000, 32'hC300_0000);
        ti_read(16'h5FF1);
        check_state("nch4");

        ti_write(16'h5FFF, 8'h12, 2'b00, 4'h0, 1'b0);
        ti_write(16'h5FFF, 8'h34, 2'b00, 4'h0, 1'b0);
        rst = 1'b1;
        tick(1);
        model_reset();
        check_state("rst_mid");
        ti_read(16'h5FFB);
        rst = 1'b0;
        tick(1);

        cru_write(16'h1101);
        cru_write(16'h1201);
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 6))
                0, 1: begin
                    case ($urandom_range(0, 4))
                        0: ra = 16'h5FFF;
                        1: ra = 16'h5FFD;
                        2: ra = 16'h5FFB;
                        3: ra = 16'h5FF9;
                        default: ra = 16'($urandom);
                    endcase
                    a0 = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
                    a1 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                    ti_write(ra, 8'($urandom), a0, a1, ($urandom_range(0, 3) == 0));
                end
                2: ack_pulse(2'($urandom), 4'($urandom), ($urandom_range(0, 2) == 0));
                3: rx_load(2'($urandom), 16'($urandom), 4'($urandom), $urandom);
                4: ti_read(16'h5FFB - 16'(2 * $urandom_range(0, 5)));
                5: cru_write({4'h1, 4'($urandom_range(0, 3)), 8'($urandom)});
                default: begin
                    if ($urandom_range(0, 3) == 0) ti_reset_pulse();
                    else cru_write({4'h1, 4'($urandom_range(1, 2)), 7'($urandom), 1'b1});
                end
            endcase
            check_state($sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
